// File: rtl/register_file.sv
// register_file: 32 x DATA_W register file, two combinational read ports and
// one write port with an extended 16-bit write address.
// Optional build macro REGFILE_R0_ZERO_EN: register 0 is hardwired to zero.
module register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        read_address_0,
  input  logic [4:0]        read_address_1,
  input  logic [15:0]       write_address_0,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_0,
  output logic [DATA_W-1:0] read_data_1
);

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned WADDR_W = 16;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] wr_index_c;
  logic              wr_upper_zero_c;
  logic              wr_fire_c;

  // Qualify the write: strobe set and all address bits above the index clear
  always_comb begin
    wr_index_c      = write_address_0[ADDR_W-1:0];
    wr_upper_zero_c = (write_address_0[WADDR_W-1:ADDR_W] == (WADDR_W-ADDR_W)'(0));
    wr_fire_c       = write_en && wr_upper_zero_c;
`ifdef REGFILE_R0_ZERO_EN
    // Register 0 is constant zero, so writes to it are dropped
    if (wr_index_c == ADDR_W'(0)) begin
      wr_fire_c = 1'b0;
    end
`endif
  end

  // Register array: async clear dominates, otherwise a qualified write lands on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire_c) begin
      regs[wr_index_c] <= write_data;
    end
  end

  // Combinational read ports; no write bypass, so new data appears only after the edge
  always_comb begin
    read_data_0 = regs[read_address_0];
    read_data_1 = regs[read_address_1];
`ifdef REGFILE_R0_ZERO_EN
    if (read_address_0 == ADDR_W'(0)) begin
      read_data_0 = '0;
    end
    if (read_address_1 == ADDR_W'(0)) begin
      read_data_1 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default DATA_W=32).
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_address_0;
  logic [4:0]  read_address_1;
  logic [15:0] write_address_0;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data_0;
  logic [31:0] read_data_1;

  int checks   = 0;
  int failures = 0;

  register_file dut (
    .clk             (clk),
    .rst             (rst),
    .read_address_0  (read_address_0),
    .read_address_1  (read_address_1),
    .write_address_0 (write_address_0),
    .write_en        (write_en),
    .write_data      (write_data),
    .read_data_0     (read_data_0),
    .read_data_1     (read_data_1)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a write at the falling edge and let it land on the next rising edge
  task automatic write_reg(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_en        = 1'b1;
    write_address_0 = addr;
    write_data      = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    write_en = 1'b0;
  endtask

  // Point both read ports and let the combinational path settle
  task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
    read_address_0 = a0;
    read_address_1 = a1;
    #1;
  endtask

  logic [31:0] r0_exp;

  initial begin
    rst             = 1'b1;
    write_en        = 1'b0;
    write_address_0 = '0;
    write_data      = '0;
    read_address_0  = '0;
    read_address_1  = '0;

    // Reads during reset
    repeat (2) @(posedge clk);
    #1;
    set_reads(5'd0, 5'd31);
    check("rst_rd0_a0", read_data_0, 32'h0);
    check("rst_rd1_a31", read_data_1, 32'h0);

    // Write edge while reset is held is discarded
    write_reg(16'h0003, 32'hCAFEF00D);
    set_reads(5'd3, 5'd3);
    check("rst_write_blocked", read_data_0, 32'h0);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_reads(5'd3, 5'd3);
    check("rst_write_not_latent", read_data_1, 32'h0);

    // write_en low at address 0 changes nothing
    write_address_0 = 16'h0000;
    write_data      = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    set_reads(5'd0, 5'd1);
    check("we0_addr0", read_data_0, 32'h0);
    check("we0_addr1", read_data_1, 32'h0);

    // Back-to-back writes on consecutive edges
    write_reg(16'h0002, 32'h87654321);
    write_reg(16'h0003, 32'hABCDEF01);
    idle();
    set_reads(5'd2, 5'd3);
    check("b2b_addr2", read_data_0, 32'h87654321);
    check("b2b_addr3", read_data_1, 32'hABCDEF01);

    // Both ports on the same register
    set_reads(5'd2, 5'd2);
    check("same_rd0", read_data_0, 32'h87654321);
    check("same_rd1", read_data_1, 32'h87654321);

    // Read during write: old value before the edge, new value after, no bypass
    write_reg(16'h0001, 32'hA5A5A5A5);
    idle();
    read_address_1  = 5'd1;
    write_en        = 1'b1;
    write_address_0 = 16'h0001;
    write_data      = 32'h12345678;
    #1;
    check("rdw_before", read_data_1, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    check("rdw_after", read_data_1, 32'h12345678);
    idle();

    // Upper write-address bits set: register 5 keeps its value
    write_reg(16'h0005, 32'h55555555);
    write_reg(16'h0025, 32'hFFFFFFFF);
    write_reg(16'h8005, 32'hFFFFFFFF);
    idle();
    set_reads(5'd5, 5'd5);
    check("upper_addr_ignored", read_data_0, 32'h55555555);

    // write_en low with a live address and data
    write_address_0 = 16'h0006;
    write_data      = 32'h66666666;
    @(posedge clk);
    #1;
    set_reads(5'd6, 5'd6);
    check("we0_addr6", read_data_0, 32'h0);

    // Register 0 behaviour depends on the build
    write_reg(16'h0000, 32'h11111111);
    idle();
`ifdef REGFILE_R0_ZERO_EN
    r0_exp = 32'h0;
`else
    r0_exp = 32'h11111111;
`endif
    set_reads(5'd0, 5'd0);
    check("r0_write", read_data_0, r0_exp);

    // Fill 4..7, then reset mid-cycle with no clock edge in between
    write_reg(16'h0004, 32'h44444444);
    write_reg(16'h0006, 32'h66666666);
    write_reg(16'h0007, 32'h77777777);
    idle();
    set_reads(5'd4, 5'd7);
    check("fill_r4", read_data_0, 32'h44444444);
    check("fill_r7", read_data_1, 32'h77777777);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 4; i < 8; i++) begin
      read_address_0 = 5'(i);
      #0.1;
      check($sformatf("async_rst_r%0d", i), read_data_0, 32'h0);
    end
    set_reads(5'd2, 5'd1);
    check("async_rst_r2", read_data_0, 32'h0);
    check("async_rst_r1", read_data_1, 32'h0);

    // First write after reset release lands on the next qualifying edge
    @(negedge clk);
    rst = 1'b0;
    write_reg(16'h0007, 32'h0BADF00D);
    idle();
    set_reads(5'd7, 5'd5);
    check("post_rst_write", read_data_0, 32'h0BADF00D);
    check("post_rst_r5_clear", read_data_1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of every data port.
REQ-002 Parameter NUM_REGS, default 32: register count, fixed at 32 for this release (5-bit read addressing).
REQ-003 Port clk, input, 1: single clock; all writes occur on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port read_address_0, input, 5: binary register index for read port 0.
REQ-006 Port read_address_1, input, 5: binary register index for read port 1.
REQ-007 Port write_address_0, input, 16: binary register index for the write port; only bits [4:0] select a register.
REQ-008 Port write_en, input, 1: write strobe, sampled at the clk rising edge.
REQ-009 Port write_data, input, DATA_W: data to be written.
REQ-010 Port read_data_0, output, DATA_W: contents of the register at read_address_0.
REQ-011 Port read_data_1, output, DATA_W: contents of the register at read_address_1.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits each, indexed 0..31.
REQ-013 Reads SHALL be combinational: each read_data_N reflects the selected register within the same cycle, with zero clock latency.
REQ-014 The two read ports SHALL be fully independent; both ports may address the same register simultaneously and each SHALL return that register's value.
REQ-015 On a clk rising edge with write_en=1 and write_address_0[15:5]=0, register write_address_0[4:0] SHALL load write_data.
REQ-016 A write with any of write_address_0[15:5] nonzero SHALL be ignored: no register changes.
REQ-017 With write_en=0, no register SHALL change, whatever write_address_0 and write_data hold.
REQ-018 Read during write to the same address: the read port SHALL show the old value until the edge and the new value immediately after it, with no same-cycle bypass.
REQ-019 An X or undriven write_data written with write_en=1 SHALL be stored as-is; the block SHALL add no data sanitising.
REQ-020 Back-to-back writes on consecutive edges to different addresses SHALL each complete in their own cycle.

Reset
REQ-021 While rst=1, all 32 registers SHALL clear to 0 asynchronously, independent of clk.
REQ-022 During reset, read_data_0 and read_data_1 SHALL read 0 for every address.
REQ-023 When rst=1 coincides with a write edge, reset SHALL take priority and the write SHALL be discarded.
REQ-024 After rst deasserts, the first write SHALL occur at the next qualifying clk rising edge.

Configuration
REQ-025 Macro REGFILE_R0_ZERO_EN, when defined: register 0 SHALL be hardwired to 0, writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0.
REQ-026 Without REGFILE_R0_ZERO_EN: register 0 SHALL be an ordinary writable register.

Verification
REQ-027 Reset, then write_en=0 with write_address_0=0 and write_data=32'hDEADBEEF over one edge -> read_data_0 (addr 0) = 0 and read_data_1 (addr 1) = 0.
REQ-028 write_en=1, write_address_0=16'h0002, write_data=32'h87654321, one edge; then write_address_0=16'h0003, write_data=32'hABCDEF01, next edge -> reading addr 2 / addr 3 returns 32'h87654321 / 32'hABCDEF01.
REQ-029 write_en=1, write_address_0=16'h0001, write_data=32'h12345678, with read_address_1=1 -> read_data_1 shows the old value before the edge and 32'h12345678 after it.
REQ-030 write_en=1, write_address_0=16'h0025, write_data=32'hFFFFFFFF, one edge -> register 5 keeps its prior value.
REQ-031 Write 32'h11111111 to address 0 -> read_data_0 = 32'h11111111 without REGFILE_R0_ZERO_EN, and 0 with it.
REQ-032 Fill registers 4..7 with nonzero data, then pulse rst mid-cycle without a clk edge -> all reads return 0 immediately.
